// File: rtl/apb_mp_pkg.sv
// rtl/apb_mp_pkg.sv - shared types and slave-select decode for the APB requester
// Purpose : FSM state type and the address-index to one-hot select decoder.
// Contents: state_e (IDLE/SETUP/ACCESS), sel_t, sel_decode().
package apb_mp_pkg;

   localparam int unsigned MAX_SLV = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   typedef struct packed {
      logic               valid;
      logic [MAX_SLV-1:0] onehot;
   } sel_t;

   // One-hot select for a slave index; valid is low (and no bit set) when the
   // index addresses a slave that does not exist.
   function automatic sel_t sel_decode(input logic [3:0] index, input int unsigned num_slv);
      sel_t r;
      r.onehot = '0;
      r.valid  = (32'(index) < num_slv);
      if (r.valid) r.onehot[index] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/apb_mp_timeout.sv
// rtl/apb_mp_timeout.sv - ACCESS wait-state counter with expiry flag
// Purpose : counts ACCESS cycles with pready low and flags the abort cycle.
// Ports   : clk_i, rst_i   clock, synchronous active-high reset
//           clr_i          clear (asserted on the cycle before ACCESS)
//           inc_i          ACCESS cycle with pready low
//           expire_o       this cycle is the last allowed wait cycle
module apb_mp_timeout #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);
   import apb_mp_pkg::*;

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;

   // The counter never passes TIMEOUT-1: at that value either pready ends the
   // transfer (inc_i low) or the transfer aborts, so no saturation is needed.
   // With TIMEOUT=0 it is held at zero and expiry is disabled.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i || (TIMEOUT == 0)) cnt_q <= '0;
      else if (inc_i)                       cnt_q <= cnt_q + 1'b1;
   end

   assign expire_o = (TIMEOUT != 0) && inc_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_mp.sv
// rtl/apb_master_mp.sv - parametrised multi-slave APB4 requester
// Purpose : accepts valid/ready commands, runs APB4 transfers to one of
//           NUM_SLV slaves selected from the address, returns a one-cycle
//           registered response with slave/decode/timeout error reporting.
// Ports   : pclk, preset                      clock, sync active-high reset
//           cmd_valid/ready/write/addr/wdata/strb   command port
//           rsp_valid/rdata/err/timeout       response port
//           psel/penable/paddr/pwrite/pwdata/pstrb  APB request outputs
//           pready/prdata/pslverr             muxed APB completion inputs
module apb_master_mp #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NUM_SLV = 4,
   parameter int unsigned SEL_LSB = 28,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic [NUM_SLV-1:0]  psel,
   output logic                penable,
   output logic [ADDR_W-1:0]   paddr,
   output logic                pwrite,
   output logic [DATA_W-1:0]   pwdata,
   output logic [DATA_W/8-1:0] pstrb,
   input  logic                pready,
   input  logic [DATA_W-1:0]   prdata,
   input  logic                pslverr
);
   import apb_mp_pkg::*;

   localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   state_e              state_q, state_d;
   logic [NUM_SLV-1:0]  psel_q, psel_d;
   logic                penable_q, penable_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic                pwrite_q, pwrite_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [DATA_W/8-1:0] pstrb_q, pstrb_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic                pend_err_q, pend_err_d;

   logic [3:0] slv_idx;
   sel_t       dec;
   logic       accept, dec_err, expire;
   logic       unused_sel;

   generate
      if (NUM_SLV == 1) begin : g_idx_one
         assign slv_idx = 4'd0;
      end else begin : g_idx_multi
         assign slv_idx = 4'(cmd_addr[SEL_LSB +: IDX_W]);
      end
   endgenerate

   assign dec        = sel_decode(slv_idx, NUM_SLV);
   assign unused_sel = ^dec;
   assign cmd_ready  = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && pready);
   assign accept     = cmd_valid && cmd_ready;
   assign dec_err    = accept && !dec.valid;

   apb_mp_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk_i    (pclk),
      .rst_i    (preset),
      .clr_i    (state_q == ST_SETUP),
      .inc_i    ((state_q == ST_ACCESS) && !pready),
      .expire_o (expire)
   );

   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      paddr_d       = paddr_q;
      pwrite_d      = pwrite_q;
      pwdata_d      = pwdata_q;
      pstrb_d       = pstrb_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
      pend_err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A decode error accepted on a completion cycle could not respond
            // alongside that completion; it is parked in pend_err_q and sent
            // here, with a fresh decode error taking its place if needed.
            if (pend_err_q || dec_err) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end
            pend_err_d = pend_err_q && dec_err;
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            // pready wins over an expiry on the same cycle.
            if (pready) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = pslverr;
               rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
               state_d     = ST_IDLE;
               psel_d      = '0;
               penable_d   = 1'b0;
               pend_err_d  = dec_err;
            end else if (expire) begin
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = ST_IDLE;
               psel_d        = '0;
               penable_d     = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A decodable command starts SETUP next cycle, from IDLE or straight
      // out of a completing ACCESS.
      if (accept && dec.valid) begin
         state_d   = ST_SETUP;
         psel_d    = dec.onehot[NUM_SLV-1:0];
         penable_d = 1'b0;
         paddr_d   = cmd_addr;
         pwrite_d  = cmd_write;
         pwdata_d  = cmd_write ? cmd_wdata : '0;
         pstrb_d   = cmd_write ? cmd_strb : '0;
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q       <= ST_IDLE;
         psel_q        <= '0;
         penable_q     <= 1'b0;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         pend_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         pend_err_q    <= pend_err_d;
      end
   end

   assign psel        = psel_q;
   assign penable     = penable_q;
   assign paddr       = paddr_q;
   assign pwrite      = pwrite_q;
   assign pwdata      = pwdata_q;
   assign pstrb       = pstrb_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_mp.sv
// tb/tb_apb_master_mp.sv - directed self-checking bench for apb_master_mp
module tb_apb_master_mp;

   logic        pclk = 1'b0;
   logic        preset;
   logic        cmd_valid, cmd_valid3, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        pready, pslverr;
   logic [31:0] prdata;

   logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, penable, pwrite;
   logic [31:0] rsp_rdata, paddr, pwdata;
   logic [3:0]  psel, pstrb;

   logic        cmd_ready3, rsp_valid3, rsp_err3, rsp_timeout3, penable3, pwrite3;
   logic [31:0] rsp_rdata3, paddr3, pwdata3;
   logic [2:0]  psel3;
   logic [3:0]  pstrb3;

   int checks = 0;
   int errors = 0;

   always #5 pclk = ~pclk;

   apb_master_mp #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SEL_LSB(28), .TIMEOUT(16)) dut (
      .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
      .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
   );

   apb_master_mp #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SEL_LSB(28), .TIMEOUT(16)) dut3 (
      .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .rsp_timeout(rsp_timeout3),
      .psel(psel3), .penable(penable3), .paddr(paddr3), .pwrite(pwrite3), .pwdata(pwdata3),
      .pstrb(pstrb3), .pready(pready), .prdata(prdata), .pslverr(pslverr)
   );

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   task automatic test_reset;
      preset = 1'b1;
      tick();
      tick();
      checks++; if ({psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin errors++; $display("FAIL reset_outputs: psel=%b penable=%b paddr=%h pwdata=%h pstrb=%b rsp_valid=%b expected all zero", psel, penable, paddr, pwdata, pstrb, rsp_valid); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      preset = 1'b0;
      tick();
   endtask

   task automatic test_read;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1000_0010;
      cmd_wdata = 32'h1111_2222; cmd_strb = 4'hF; pready = 1'b0;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL read_ready_idle: got %b expected 1", cmd_ready); end
      tick();
      cmd_valid = 1'b0; pready = 1'b1; prdata = 32'hDEAD_BEEF; pslverr = 1'b0;
      checks++; if (psel !== 4'b0010 || penable !== 1'b0) begin errors++; $display("FAIL read_setup: psel=%b penable=%b expected 0010/0", psel, penable); end
      checks++; if (paddr !== 32'h1000_0010 || pwrite !== 1'b0 || pwdata !== 32'h0 || pstrb !== 4'h0) begin errors++; $display("FAIL read_setup_data: paddr=%h pwrite=%b pwdata=%h pstrb=%b expected 10000010/0/0/0", paddr, pwrite, pwdata, pstrb); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL read_ready_setup: got %b expected 0", cmd_ready); end
      tick();
      checks++; if (psel !== 4'b0010 || penable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL read_access: psel=%b penable=%b rsp_valid=%b expected 0010/1/0", psel, penable, rsp_valid); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin errors++; $display("FAIL read_rsp: valid=%b rdata=%h err=%b expected 1/deadbeef/0", rsp_valid, rsp_rdata, rsp_err); end
      checks++; if (psel !== 4'b0000 || penable !== 1'b0) begin errors++; $display("FAIL read_idle: psel=%b penable=%b expected 0000/0", psel, penable); end
      pready = 1'b0;
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rsp_pulse: got %b expected 0", rsp_valid); end
   endtask

   task automatic test_write;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h2000_0004;
      cmd_wdata = 32'hA5A5_0F0F; cmd_strb = 4'b0101; pready = 1'b0; prdata = 32'h1234_5678;
      tick();
      cmd_valid = 1'b0;
      checks++; if (psel !== 4'b0100 || pwrite !== 1'b1 || pwdata !== 32'hA5A5_0F0F || pstrb !== 4'b0101 || penable !== 1'b0) begin errors++; $display("FAIL write_setup: psel=%b pwrite=%b pwdata=%h pstrb=%b penable=%b", psel, pwrite, pwdata, pstrb, penable); end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) pready = 1'b1;
         checks++; if ({penable, psel, pwdata, pstrb} !== {1'b1, 4'b0100, 32'hA5A5_0F0F, 4'b0101}) begin errors++; $display("FAIL write_access_stable[%0d]: penable=%b psel=%b pwdata=%h pstrb=%b expected 1/0100/a5a50f0f/0101", i, penable, psel, pwdata, pstrb); end
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_no_early_rsp[%0d]: got %b expected 0", i, rsp_valid); end
      end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL write_rsp: valid=%b err=%b rdata=%h expected 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
      checks++; if (paddr !== 32'h2000_0004 || pwdata !== 32'hA5A5_0F0F) begin errors++; $display("FAIL write_idle_hold: paddr=%h pwdata=%h expected 20000004/a5a50f0f", paddr, pwdata); end
      pready = 1'b0;
      tick();
   endtask

   task automatic test_pslverr;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1000_0000;
      pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL pslverr_rsp: valid=%b err=%b rdata=%h timeout=%b expected 1/1/0/0", rsp_valid, rsp_err, rsp_rdata, rsp_timeout); end
      pslverr = 1'b0; pready = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3000_0000;
      pready = 1'b1; prdata = 32'hCAFE_0001;
      tick();
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_setup: got %b expected 0", cmd_ready); end
      cmd_write = 1'b1; cmd_addr = 32'h0000_0008; cmd_wdata = 32'h0000_00FF; cmd_strb = 4'b0001;
      tick();
      checks++; if (cmd_ready !== 1'b1 || psel !== 4'b1000 || penable !== 1'b1) begin errors++; $display("FAIL b2b_first_access: ready=%b psel=%b penable=%b expected 1/1000/1", cmd_ready, psel, penable); end
      tick();
      cmd_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL b2b_rsp1: valid=%b rdata=%h expected 1/cafe0001", rsp_valid, rsp_rdata); end
      checks++; if (psel !== 4'b0001 || penable !== 1'b0 || pwrite !== 1'b1 || pstrb !== 4'b0001) begin errors++; $display("FAIL b2b_second_setup: psel=%b penable=%b pwrite=%b pstrb=%b expected 0001/0/1/0001", psel, penable, pwrite, pstrb); end
      tick();
      checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_second_access: penable=%b rsp_valid=%b expected 1/0", penable, rsp_valid); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || psel !== 4'b0000) begin errors++; $display("FAIL b2b_rsp2: valid=%b rdata=%h psel=%b expected 1/0/0000", rsp_valid, rsp_rdata, psel); end
      pready = 1'b0;
      tick();
   endtask

   task automatic test_timeout;
      int n;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0020; pready = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      n = 0;
      while (penable === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      checks++; if (n !== 16) begin errors++; $display("FAIL timeout_access_cycles: got %0d expected 16", n); end
      checks++; if (psel !== 4'b0000 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rsp: psel=%b valid=%b err=%b timeout=%b rdata=%h expected 0000/1/1/1/0", psel, rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle_ready: got %b expected 1", cmd_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL timeout_rsp_pulse: got %b expected 0", rsp_valid); end

      cmd_valid = 1'b1; prdata = 32'h5A5A_5A5A;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 1; i <= 16; i++) begin
         if (i == 16) pready = 1'b1;
         if (i == 16) begin
            checks++; if (penable !== 1'b1) begin errors++; $display("FAIL timeout_edge_access: penable=%b expected 1", penable); end
         end
         tick();
      end
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL timeout_edge_rsp: valid=%b err=%b timeout=%b rdata=%h expected 1/0/0/5a5a5a5a", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
      pready = 1'b0;
      tick();
   endtask

   task automatic test_decode_err;
      cmd_valid3 = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3000_0000;
      checks++; if (cmd_ready3 !== 1'b1) begin errors++; $display("FAIL dec_ready: got %b expected 1", cmd_ready3); end
      tick();
      cmd_valid3 = 1'b0;
      checks++; if (psel3 !== 3'b000 || penable3 !== 1'b0 || rsp_valid3 !== 1'b1 || rsp_err3 !== 1'b1 || rsp_timeout3 !== 1'b0 || rsp_rdata3 !== 32'h0) begin errors++; $display("FAIL dec_err_rsp: psel=%b penable=%b valid=%b err=%b timeout=%b rdata=%h expected 000/0/1/1/0/0", psel3, penable3, rsp_valid3, rsp_err3, rsp_timeout3, rsp_rdata3); end
      tick();
      checks++; if (rsp_valid3 !== 1'b0 || cmd_ready3 !== 1'b1) begin errors++; $display("FAIL dec_err_after: valid=%b ready=%b expected 0/1", rsp_valid3, cmd_ready3); end
      cmd_valid3 = 1'b1; cmd_addr = 32'h2000_0000; pready = 1'b1; prdata = 32'h0000_3333;
      tick();
      cmd_valid3 = 1'b0;
      checks++; if (psel3 !== 3'b100) begin errors++; $display("FAIL dec_slave2_psel: got %b expected 100", psel3); end
      tick();
      tick();
      checks++; if (rsp_valid3 !== 1'b1 || rsp_err3 !== 1'b0 || rsp_rdata3 !== 32'h0000_3333) begin errors++; $display("FAIL dec_slave2_rsp: valid=%b err=%b rdata=%h expected 1/0/00003333", rsp_valid3, rsp_err3, rsp_rdata3); end
      pready = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1000_0040;
      cmd_wdata = 32'h7777_8888; cmd_strb = 4'hF; pready = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rst_mid_access: penable=%b expected 1", penable); end
      preset = 1'b1;
      tick();
      preset = 1'b0;
      checks++; if ({psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin errors++; $display("FAIL rst_mid_outputs: psel=%b penable=%b paddr=%h pwdata=%h rsp_valid=%b expected all zero", psel, penable, paddr, pwdata, rsp_valid); end
      tick();
      checks++; if (rsp_valid !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rsp: valid=%b penable=%b expected 0/0", rsp_valid, penable); end
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0000;
      pready = 1'b1; prdata = 32'h0BAD_F00D;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL rst_mid_recover: valid=%b err=%b rdata=%h expected 1/0/0badf00d", rsp_valid, rsp_err, rsp_rdata); end
      pready = 1'b0;
      tick();
   endtask

   initial begin
      preset = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0; cmd_write = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      test_reset();
      test_read();
      test_write();
      test_pslverr();
      test_back_to_back();
      test_timeout();
      test_decode_err();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master_mp.md
Name: apb_master_mp

Overview:
- Parametrised APB4 requester (next generation of the single-slave APB master).
- Takes commands from a local valid/ready request port and drives an APB bus to NUM_SLV slaves through one-hot psel, decoding the slave index from the address.
- Adds byte strobes, back-to-back transfers, a wait-state timeout and a registered one-cycle response port with error reporting.
- Sits between the core-side command logic and the APB interconnect; the interconnect muxes pready, prdata and pslverr back by psel.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; multiple of 8
NUM_SLV, 4, number of slaves (1..16)
SEL_LSB, 28, LSB of the slave-index field; index = cmd_addr[SEL_LSB +: clog2(NUM_SLV)] (index 0 when NUM_SLV=1)
TIMEOUT, 16, max ACCESS wait cycles with pready low; 0 disables the timeout

Ports:
pclk  in  1  clock, all logic on rising edge
preset  in  1  reset; one clock; reset is synchronous and active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  pslverr, decode error or timeout
rsp_timeout  out  1  error caused by timeout
psel  out  NUM_SLV  one-hot slave select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  APB strobes
pready  in  1  muxed slave ready
prdata  in  DATA_W  muxed read data
pslverr  in  1  muxed slave error

Behaviour:
- Reset: state=IDLE; psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, pstrb=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter=0.
- Reset asserted mid-transfer aborts it at that edge; no response is produced.
- All APB and response outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- cmd_ready = (state==IDLE) || (state==ACCESS && pready). It is never high during SETUP or on a timeout-abort cycle.
- Accept at edge k with a valid index (index < NUM_SLV):
  - cycle k+1 is SETUP: psel one-hot of index, penable=0, paddr/pwrite latched from the command.
  - Writes: pwdata=cmd_wdata, pstrb=cmd_strb. Reads: pwdata=0, pstrb=0.
- SETUP -> ACCESS unconditionally; penable=1 in ACCESS; psel, paddr, pwrite, pwdata and pstrb stay stable.
- ACCESS with pready=1 completes the transfer. In the next cycle:
  - rsp_valid=1, rsp_err=pslverr, rsp_timeout=0.
  - rsp_rdata=prdata for a read without pslverr, else 0.
- At completion, if a command is accepted in the same cycle, the next state is SETUP (back-to-back, no idle cycle). Otherwise IDLE with psel=0 and penable=0.
- paddr, pwrite, pwdata and pstrb hold their last value in IDLE.
- Wait counter: cleared on entry to ACCESS; increments each ACCESS cycle with pready=0.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 with pready=0, the transfer aborts at that edge.
  - Next cycle: IDLE, psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A pready arriving on the abort cycle takes precedence: normal completion.
- Decode error (index >= NUM_SLV, only possible when NUM_SLV is not a power of 2):
  - command accepted, no APB cycle, FSM stays IDLE.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- rsp_valid is high exactly one cycle per accepted command. There is no response back-pressure.
- pready, prdata and pslverr are ignored outside ACCESS.

Decomposition:
- Package apb_mp_pkg: state enum (IDLE/SETUP/ACCESS) and function sel_decode(index, NUM_SLV) returning the one-hot select plus a valid flag.
- Sub-module apb_mp_timeout: wait counter with clear/inc/expire. Parametrised by TIMEOUT and tied off when TIMEOUT=0.
- FSM, datapath registers and response register stay in the top module.

Test Plan:
- Read: cmd addr=0x1000_0010, slave 1 returns prdata=0xDEADBEEF with pready on the first ACCESS cycle -> psel=4'b0010 in SETUP and ACCESS; rsp_valid 3 cycles after accept with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write: addr=0x2000_0004, wdata=0xA5A5_0F0F, strb=4'b0101, pready low for 3 cycles -> pwdata/pstrb stable through 4 ACCESS cycles; response err=0, rdata=0; read transfers show pstrb=0.
- Back-to-back: second cmd_valid held during the first ACCESS -> accepted on the pready cycle; next cycle is SETUP with penable=0, no IDLE gap; two rsp_valid pulses.
- Timeout: TIMEOUT=16, pready held low -> abort after 16 ACCESS cycles; psel=0 next cycle; rsp_err=1, rsp_timeout=1. Repeat with pready rising on cycle 16 -> normal completion.
- Errors: pslverr=1 with pready on a read -> rsp_err=1, rsp_rdata=0. NUM_SLV=3, addr index 3 -> no psel, response next cycle with err=1.
- Reset: preset pulsed during ACCESS -> all outputs zero after that edge, no rsp_valid, new command then completes normally.
